// File: rtl/uart_csr_fifo.sv
// Wishbone-pipelined CSR block for a UART: TX/RX byte FIFOs, sticky overflow
// flags, interrupt enables and a registered level interrupt.
module uart_csr_fifo #(
   parameter int TX_DEPTH = 16,
   parameter int RX_DEPTH = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [4:2]  wb_adr_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_dat_i,
   output logic        wb_ack_o,
   output logic        wb_stall_o,
   output logic        wb_err_o,
   output logic        wb_rty_o,
   output logic [31:0] wb_dat_o,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        irq_o
);

   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int RX_AW = $clog2(RX_DEPTH);

   localparam logic [2:0] ADR_STATUS = 3'd0;
   localparam logic [2:0] ADR_DATA   = 3'd1;
   localparam logic [2:0] ADR_IRQ_EN = 3'd2;

   logic [7:0]       tx_mem_q [TX_DEPTH];
   logic [7:0]       rx_mem_q [RX_DEPTH];

   logic [TX_AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;
   logic [RX_AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [RX_AW:0]   rx_cnt_q, rx_cnt_d;
   logic             tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
   logic [2:0]       irq_en_q, irq_en_d;
   logic             ack_q, ack_d, irq_q, irq_d;
   logic [31:0]      dat_q, dat_d;

   logic accept, wr_data, rd_data, wr_status, wr_irq_en;
   logic tx_full, tx_empty, tx_pop, tx_push_ok;
   logic rx_full, rx_not_empty, rx_pop, rx_push_ok;
   logic [31:0] status, rdata;
   logic unused_bits;

   // busy is exactly the ack cycle: one request in flight, cleared as it acks
   assign accept     = wb_cyc_i & wb_stb_i & ~ack_q;
   assign wb_stall_o = wb_cyc_i & wb_stb_i & ack_q;
   assign wb_ack_o   = ack_q;
   assign wb_dat_o   = dat_q;
   assign wb_err_o   = 1'b0;
   assign wb_rty_o   = 1'b0;
   assign irq_o      = irq_q;

   assign wr_data   = accept &  wb_we_i & (wb_adr_i == ADR_DATA) & wb_sel_i[0];
   assign rd_data   = accept & ~wb_we_i & (wb_adr_i == ADR_DATA);
   assign wr_status = accept &  wb_we_i & (wb_adr_i == ADR_STATUS) & wb_sel_i[0];
   assign wr_irq_en = accept &  wb_we_i & (wb_adr_i == ADR_IRQ_EN) & wb_sel_i[0];

   assign tx_full      = (tx_cnt_q == (TX_AW+1)'(TX_DEPTH));
   assign tx_empty     = (tx_cnt_q == '0);
   assign tx_valid_o   = ~tx_empty;
   assign tx_data_o    = tx_mem_q[tx_rd_q];
   assign tx_pop       = tx_valid_o & tx_ready_i;
   assign tx_push_ok   = wr_data & (~tx_full | tx_pop);

   assign rx_full      = (rx_cnt_q == (RX_AW+1)'(RX_DEPTH));
   assign rx_not_empty = (rx_cnt_q != '0);
   assign rx_pop       = rd_data & rx_not_empty;
   assign rx_push_ok   = rx_valid_i & (~rx_full | rx_pop);

   assign unused_bits = ^{wb_dat_i[31:8], wb_dat_i[7:4], wb_sel_i[3:1]};

   always_comb begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      status        = '0;
      status[0]     = tx_full;
      status[1]     = rx_not_empty;
      status[2]     = rx_ovf_q;
      status[3]     = tx_ovf_q;
      status[4]     = tx_empty;
      status[15:8]  = 8'(rx_cnt_q);
      status[23:16] = 8'(tx_cnt_q);

      rdata = '0;
      case (wb_adr_i)
         ADR_STATUS: rdata = status;
         ADR_DATA:   rdata = rx_not_empty ? {24'b0, rx_mem_q[rx_rd_q]} : 32'b0;
         ADR_IRQ_EN: rdata = {29'b0, irq_en_q};
         default:    rdata = '0;
      endcase

      ack_d = accept;
      dat_d = dat_q;
      if (accept) dat_d = wb_we_i ? 32'b0 : rdata;

      tx_wr_d  = tx_push_ok ? tx_wr_q + TX_AW'(1) : tx_wr_q;
      tx_rd_d  = tx_pop     ? tx_rd_q + TX_AW'(1) : tx_rd_q;
      tx_cnt_d = tx_cnt_q;
      if (tx_push_ok && !tx_pop)      tx_cnt_d = tx_cnt_q + (TX_AW+1)'(1);
      else if (!tx_push_ok && tx_pop) tx_cnt_d = tx_cnt_q - (TX_AW+1)'(1);

      rx_wr_d  = rx_push_ok ? rx_wr_q + RX_AW'(1) : rx_wr_q;
      rx_rd_d  = rx_pop     ? rx_rd_q + RX_AW'(1) : rx_rd_q;
      rx_cnt_d = rx_cnt_q;
      if (rx_push_ok && !rx_pop)      rx_cnt_d = rx_cnt_q + (RX_AW+1)'(1);
      else if (!rx_push_ok && rx_pop) rx_cnt_d = rx_cnt_q - (RX_AW+1)'(1);

      // clear first so a same-cycle overflow wins over the W1C
      tx_ovf_d = tx_ovf_q & ~(wr_status & wb_dat_i[3]);
      rx_ovf_d = rx_ovf_q & ~(wr_status & wb_dat_i[2]);
      if (wr_data && !tx_push_ok)    tx_ovf_d = 1'b1;
      if (rx_valid_i && !rx_push_ok) rx_ovf_d = 1'b1;

      irq_en_d = wr_irq_en ? wb_dat_i[2:0] : irq_en_q;

      irq_d = (irq_en_q[0] & rx_not_empty) |
              (irq_en_q[1] & tx_empty) |
              (irq_en_q[2] & (rx_ovf_q | tx_ovf_q));
   end

   always_ff @(posedge clk_i) begin
      // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
      if (rst_i) begin
         ack_q    <= 1'b0;
         dat_q    <= '0;
         irq_q    <= 1'b0;
         irq_en_q <= '0;
         tx_ovf_q <= 1'b0;
         rx_ovf_q <= 1'b0;
         tx_wr_q  <= '0;
         tx_rd_q  <= '0;
         tx_cnt_q <= '0;
         rx_wr_q  <= '0;
         rx_rd_q  <= '0;
         rx_cnt_q <= '0;
      end else begin
         ack_q    <= ack_d;
         dat_q    <= dat_d;
         irq_q    <= irq_d;
         irq_en_q <= irq_en_d;
         tx_ovf_q <= tx_ovf_d;
         rx_ovf_q <= rx_ovf_d;
         tx_wr_q  <= tx_wr_d;
         tx_rd_q  <= tx_rd_d;
         tx_cnt_q <= tx_cnt_d;
         rx_wr_q  <= rx_wr_d;
         rx_rd_q  <= rx_rd_d;
         rx_cnt_q <= rx_cnt_d;
      end
   end

   // NOTE: storage arrays are not reset; the pointers and levels define what is valid.
   always_ff @(posedge clk_i) begin
      if (!rst_i && tx_push_ok) tx_mem_q[tx_wr_q] <= wb_dat_i[7:0];
      if (!rst_i && rx_push_ok) rx_mem_q[rx_wr_q] <= rx_data_i;
   end

endmodule
